// File: rtl/led_timer.sv
// rtl/led_timer.sv - countdown timer driving a 10-LED bar graph with a sticky timeout flag
module led_timer #(
  parameter int STEP_CYCLES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Reconfigure,
  input  logic       En,
  output logic [9:0] LED,
  output logic       LED_timeout
);

  localparam int PRE_W = $clog2(STEP_CYCLES);

  // Last prescaler value of each step period, P(level) = max(STEP_CYCLES >> level, 1)
  localparam int P0 = STEP_CYCLES;
  localparam int P1 = ((STEP_CYCLES >> 1) < 1) ? 1 : (STEP_CYCLES >> 1);
  localparam int P2 = ((STEP_CYCLES >> 2) < 1) ? 1 : (STEP_CYCLES >> 2);
  localparam int P3 = ((STEP_CYCLES >> 3) < 1) ? 1 : (STEP_CYCLES >> 3);

  localparam logic [PRE_W-1:0] P0_M1 = PRE_W'(P0 - 1);
  localparam logic [PRE_W-1:0] P1_M1 = PRE_W'(P1 - 1);
  localparam logic [PRE_W-1:0] P2_M1 = PRE_W'(P2 - 1);
  localparam logic [PRE_W-1:0] P3_M1 = PRE_W'(P3 - 1);

  logic [1:0]       level;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] step_last;

  always_comb begin
    step_last = P0_M1;
    case (level)
      2'd0: step_last = P0_M1;
      2'd1: step_last = P1_M1;
      2'd2: step_last = P2_M1;
      2'd3: step_last = P3_M1;
      default: step_last = P0_M1;
    endcase
  end

  // Inputs are compared against 1'b1 so that X/Z falls through to the restart branch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level       <= 2'd0;
      pre         <= '0;
      LED         <= 10'h3FF;
      LED_timeout <= 1'b0;
    end else if (Reconfigure == 1'b1) begin
      level       <= level + 2'd1;
      pre         <= '0;
      LED         <= 10'h3FF;
      LED_timeout <= 1'b0;
    end else if (En == 1'b1) begin
      if (!LED_timeout) begin
        if (pre == step_last) begin
          pre <= '0;
          LED <= {1'b0, LED[9:1]};
          if (LED[9:1] == 9'd0) begin
            LED_timeout <= 1'b1;
          end
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end else begin
      pre         <= '0;
      LED         <= 10'h3FF;
      LED_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_timer.sv
// tb/tb_led_timer.sv - randomized and directed bench for led_timer against an elapsed-time model
module tb_led_timer;

  localparam int STEP = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Reconfigure = 1'b0;
  logic       En = 1'b0;
  logic [9:0] LED;
  logic       LED_timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  led_timer #(.STEP_CYCLES(STEP)) dut (
    .clk(clk),
    .rst(rst),
    .Reconfigure(Reconfigure),
    .En(En),
    .LED(LED),
    .LED_timeout(LED_timeout)
  );

  always #5 clk = ~clk;

  function automatic int period(input int l);
    int p;
    p = STEP >> l;
    return (p < 1) ? 1 : p;
  endfunction

  // Model: speed level plus number of enabled edges since the last restart
  int m_level = 0;
  int m_k     = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_level = 0;
      m_k     = 0;
    end else if (Reconfigure === 1'b1) begin
      m_level = (m_level + 1) % 4;
      m_k     = 0;
    end else if (En === 1'b1) begin
      if (m_k < 10 * period(m_level)) m_k = m_k + 1;
    end else begin
      m_k = 0;
    end
  end

  function automatic logic [9:0] exp_led();
    logic [9:0] full;
    full = 10'h3FF;
    return full >> (m_k / period(m_level));
  endfunction

  function automatic logic exp_to();
    return (m_k >= 10 * period(m_level));
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_led", LED, exp_led());
      chk("model_timeout", {9'd0, LED_timeout}, {9'd0, exp_to()});
    end
  end

  // Hold inputs for n rising edges, then return 2 time units after the last one
  task automatic drive(input logic en, input logic rc, input int n);
    En = en;
    Reconfigure = rc;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    chk_on = 1'b1;
    #2;
    rst = 1'b1;
    chk("reset_led", LED, 10'h3FF);
    chk("reset_timeout", {9'd0, LED_timeout}, 10'd0);
    drive(1'b0, 1'b0, 3);
    chk("idle_led", LED, 10'h3FF);

    drive(1'b1, 1'b0, 12);
    chk("l0_edge12", LED, 10'h1FF);
    drive(1'b1, 1'b0, 12);
    chk("l0_edge24", LED, 10'h0FF);
    drive(1'b1, 1'b0, 96);
    chk("l0_edge120_led", LED, 10'h000);
    chk("l0_edge120_to", {9'd0, LED_timeout}, 10'd1);
    drive(1'b1, 1'b0, 10);
    chk("l0_edge130_to", {9'd0, LED_timeout}, 10'd1);

    drive(1'b0, 1'b0, 1);
    chk("restart_to", {9'd0, LED_timeout}, 10'd0);
    drive(1'b1, 1'b0, 119);
    chk("rerun_edge119_led", LED, 10'h001);
    chk("rerun_edge119_to", {9'd0, LED_timeout}, 10'd0);
    drive(1'b1, 1'b0, 1);
    chk("rerun_edge120_to", {9'd0, LED_timeout}, 10'd1);
    drive(1'b1, 1'b0, 30);

    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 50);
    chk("abort_edge50", LED, 10'h03F);
    drive(1'b0, 1'b0, 1);
    chk("abort_led", LED, 10'h3FF);

    drive(1'b0, 1'b1, 1);
    drive(1'b1, 1'b0, 59);
    chk("l1_edge59_to", {9'd0, LED_timeout}, 10'd0);
    drive(1'b1, 1'b0, 1);
    chk("l1_edge60_to", {9'd0, LED_timeout}, 10'd1);
    drive(1'b0, 1'b1, 3);
    drive(1'b1, 1'b0, 119);
    chk("wrap_edge119_to", {9'd0, LED_timeout}, 10'd0);
    drive(1'b1, 1'b0, 1);
    chk("wrap_edge120_to", {9'd0, LED_timeout}, 10'd1);

    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 60);
    chk("pre_reset_led", LED, 10'h01F);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset_led", LED, 10'h3FF);
    chk("async_reset_to", {9'd0, LED_timeout}, 10'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    drive(1'b0, 1'b1, 3);
    drive(1'b1, 1'b0, 9);
    chk("l3_edge9_led", LED, 10'h001);
    chk("l3_edge9_to", {9'd0, LED_timeout}, 10'd0);
    drive(1'b1, 1'b0, 1);
    chk("l3_edge10_to", {9'd0, LED_timeout}, 10'd1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1);
        rst = 1'b1;
      end else begin
        drive(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
              ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 1);
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
